// File: rtl/imm_instr_encoder_if.sv
// ============================================================================
//  Module      : imm_instr_encoder_if
//  Description : Request port and instruction-word stream of imm_instr_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rn;
  logic [63:0] req_imm;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_word;
  logic        ir_last;
  logic        err;

  modport master (
    output req_valid, req_op, req_rd, req_rn, req_imm, ir_ready,
    input  req_ready, ir_valid, ir_word, ir_last, err
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rn, req_imm, ir_ready,
    output req_ready, ir_valid, ir_word, ir_last, err
  );
endinterface

`default_nettype wire

// File: rtl/imm_instr_encoder.sv
// ============================================================================
//  Module      : imm_instr_encoder
//  Description : Encodes immediate-format requests (logic, arith, shift,
//                MOVZ/MOVK, multi-word LOADK) into 32-bit instruction words.
//                Define LOADK_SKIP_ZERO_EN to drop MOVKs of zero halfwords.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_instr_encoder #(
  parameter logic       SF_BIT    = 1'b1,
  parameter logic [1:0] SHIFT_OPC = 2'b10
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  imm_instr_encoder_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q;
  logic        rdy_q;
  logic        ir_valid_q;
  logic [31:0] ir_word_q;
  logic        ir_last_q;
  logic        err_q;
  logic [63:0] imm_q;
  logic [4:0]  rd_q;
  logic [1:0]  hw_q;

  logic [31:0] word_d;
  logic        last_d;
  logic        err_d;
  logic        legal_d;
  logic [2:0]  acc_nxt;
  logic [2:0]  busy_nxt;
  logic [2:0]  after_nxt;

  function automatic logic [31:0] mov_word(input logic movz, input logic [1:0] hw,
                                           input logic [15:0] half, input logic [4:0] rd);
    mov_word = {SF_BIT, (movz ? 2'b10 : 2'b11), 6'b100101, hw, half, rd};
  endfunction

  // next_hw returns {found, index} of the next LOADK halfword after cur
`ifdef LOADK_SKIP_ZERO_EN
  function automatic logic [2:0] next_hw(input logic [63:0] imm, input logic [1:0] cur);
    next_hw = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      if ((2'(k) > cur) && (imm[k*16 +: 16] != 16'h0)) next_hw = {1'b1, 2'(k)};
    end
  endfunction

  assign acc_nxt   = next_hw(bus.req_imm, 2'd0);
  assign busy_nxt  = next_hw(imm_q, hw_q);
  assign after_nxt = next_hw(imm_q, busy_nxt[1:0]);
`else
  function automatic logic [2:0] next_hw(input logic [1:0] cur);
    next_hw = (cur == 2'd3) ? 3'b000 : {1'b1, cur + 2'd1};
  endfunction

  assign acc_nxt   = next_hw(2'd0);
  assign busy_nxt  = next_hw(hw_q);
  assign after_nxt = next_hw(busy_nxt[1:0]);
`endif

  always_comb begin
    word_d  = 32'h0;
    last_d  = 1'b1;
    err_d   = 1'b0;
    legal_d = 1'b1;
    case (bus.req_op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        word_d = {SF_BIT, bus.req_op[1:0], 7'b1001000, bus.req_imm[11:0], bus.req_rn, bus.req_rd};
        err_d  = |bus.req_imm[63:12];
      end
      4'd4, 4'd5, 4'd6, 4'd7: begin
        word_d = {SF_BIT, bus.req_op[1:0], 5'b10001, 2'b00, bus.req_imm[11:0], bus.req_rn, bus.req_rd};
        err_d  = |bus.req_imm[63:12];
      end
      4'd8, 4'd9: begin
        word_d = {SF_BIT, SHIFT_OPC, 7'b1001101, (bus.req_op == 4'd8), 5'b00000,
                  bus.req_imm[5:0], bus.req_rn, bus.req_rd};
        err_d  = |bus.req_imm[63:6];
      end
      4'd10, 4'd11: begin
        word_d = mov_word(bus.req_op == 4'd10, bus.req_imm[17:16], bus.req_imm[15:0], bus.req_rd);
        err_d  = |bus.req_imm[63:18];
      end
      4'd12: begin
        word_d = mov_word(1'b1, 2'd0, bus.req_imm[15:0], bus.req_rd);
        last_d = ~acc_nxt[2];
      end
      default: begin
        legal_d = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_word_q  <= 32'h0;
      ir_last_q  <= 1'b0;
      err_q      <= 1'b0;
      imm_q      <= 64'h0;
      rd_q       <= 5'h0;
      hw_q       <= 2'd0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (bus.req_valid && rdy_q) begin
            err_q <= err_d;
            // illegal ops are swallowed: no word, ready stays high
            if (legal_d) begin
              ir_word_q  <= word_d;
              ir_last_q  <= last_d;
              ir_valid_q <= 1'b1;
              rdy_q      <= 1'b0;
              imm_q      <= bus.req_imm;
              rd_q       <= bus.req_rd;
              hw_q       <= 2'd0;
              state_q    <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (ir_valid_q && bus.ir_ready) begin
            if (!ir_last_q) begin
              hw_q      <= busy_nxt[1:0];
              ir_word_q <= mov_word(1'b0, busy_nxt[1:0],
                                    imm_q[{busy_nxt[1:0], 4'b0000} +: 16], rd_q);
              ir_last_q <= ~after_nxt[2];
            end else begin
              ir_valid_q <= 1'b0;
              rdy_q      <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.ir_word   = ir_word_q;
  assign bus.ir_last   = ir_last_q;
  assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_instr_encoder.sv
// ============================================================================
//  Module      : tb_imm_instr_encoder
//  Description : Directed vector bench for imm_instr_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_instr_encoder;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [63:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  vec_t vecs [12];
  logic [31:0] ew [4];

  imm_instr_encoder_if bus ();

  imm_instr_encoder dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [63:0] imm);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 64'(bus.req_ready), 64'd1);
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rn    = rn;
    bus.req_imm   = imm;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Expects ew[0..n-1] on consecutive cycles; caller is #1 after the accept edge
  task automatic check_stream(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_valid"}, 64'(bus.ir_valid), 64'd1);
      chk({name, "_word"}, 64'(bus.ir_word), 64'(ew[i]));
      chk({name, "_last"}, 64'(bus.ir_last), 64'(i == n - 1));
      @(posedge clk);
      #1;
    end
    chk({name, "_idle"}, 64'(bus.ir_valid), 64'd0);
    chk({name, "_ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_rd    = 5'd0;
    bus.req_rn    = 5'd0;
    bus.req_imm   = 64'd0;
    bus.ir_ready  = 1'b1;

    vecs[0]  = '{4'd4,  5'd1,  5'd2,  64'd5,          32'h91001441, 1'b0};
    vecs[1]  = '{4'd8,  5'd4,  5'd5,  64'd3,          32'hD3600CA4, 1'b0};
    vecs[2]  = '{4'd4,  5'd1,  5'd2,  64'h1000,       32'h91000041, 1'b1};
    vecs[3]  = '{4'd0,  5'd0,  5'd0,  64'hFFF,        32'h923FFC00, 1'b0};
    vecs[4]  = '{4'd1,  5'd31, 5'd31, 64'd1,          32'hB20007FF, 1'b0};
    vecs[5]  = '{4'd7,  5'd1,  5'd1,  64'd0,          32'hF1000021, 1'b0};
    vecs[6]  = '{4'd9,  5'd2,  5'd3,  64'd63,         32'hD340FC62, 1'b0};
    vecs[7]  = '{4'd8,  5'd0,  5'd0,  64'd64,         32'hD3600000, 1'b1};
    vecs[8]  = '{4'd10, 5'd5,  5'd0,  64'h3_1234,     32'hD2E24685, 1'b0};
    vecs[9]  = '{4'd11, 5'd0,  5'd0,  64'h4_FFFF,     32'hF29FFFE0, 1'b1};
    vecs[10] = '{4'd2,  5'd7,  5'd8,  64'h7FF,        32'hD21FFD07, 1'b0};
    vecs[11] = '{4'd5,  5'd0,  5'd0,  64'd1,          32'hB1000400, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir_valid", 64'(bus.ir_valid), 64'd0);
    chk("rst_ir_word", 64'(bus.ir_word), 64'd0);
    chk("rst_ir_last", 64'(bus.ir_last), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_req_ready", 64'(bus.req_ready), 64'd1);

    // single-word vectors
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].imm);
      chk($sformatf("v%0d_valid", i), 64'(bus.ir_valid), 64'd1);
      chk($sformatf("v%0d_word", i), 64'(bus.ir_word), 64'(vecs[i].word));
      chk($sformatf("v%0d_last", i), 64'(bus.ir_last), 64'd1);
      chk($sformatf("v%0d_err", i), 64'(bus.err), 64'(vecs[i].err));
      chk($sformatf("v%0d_busy", i), 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done", i), 64'(bus.ir_valid), 64'd0);
      chk($sformatf("v%0d_errpulse", i), 64'(bus.err), 64'd0);
      chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'd1);
    end

    // illegal op
    send(4'd14, 5'd1, 5'd2, 64'd0);
    chk("ill_err", 64'(bus.err), 64'd1);
    chk("ill_valid", 64'(bus.ir_valid), 64'd0);
    chk("ill_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("ill_err_clr", 64'(bus.err), 64'd0);
    chk("ill_valid2", 64'(bus.ir_valid), 64'd0);

    // LOADK streaming
    send(4'd12, 5'd3, 5'd0, 64'h0001_0000_0000_ABCD);
    chk("lk_err", 64'(bus.err), 64'd0);
`ifdef LOADK_SKIP_ZERO_EN
    ew[0] = 32'hD29579A3;
    ew[1] = 32'hF2E00023;
    check_stream("lk", 2);
`else
    ew[0] = 32'hD29579A3;
    ew[1] = 32'hF2A00003;
    ew[2] = 32'hF2C00003;
    ew[3] = 32'hF2E00023;
    check_stream("lk", 4);
`endif

    // LOADK of zero
    send(4'd12, 5'd6, 5'd0, 64'd0);
`ifdef LOADK_SKIP_ZERO_EN
    ew[0] = 32'hD2800006;
    check_stream("lk0", 1);
`else
    ew[0] = 32'hD2800006;
    ew[1] = 32'hF2A00006;
    ew[2] = 32'hF2C00006;
    ew[3] = 32'hF2E00006;
    check_stream("lk0", 4);
`endif

    // back-pressure mid-LOADK, then reset mid-stream
    bus.ir_ready = 1'b0;
    send(4'd12, 5'd9, 5'd0, 64'h0004_0003_0002_0001);
    chk("bp_w0", 64'(bus.ir_word), 64'hD2800029);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_valid%0d", c), 64'(bus.ir_valid), 64'd1);
      chk($sformatf("bp_hold_word%0d", c), 64'(bus.ir_word), 64'hD2800029);
      chk($sformatf("bp_hold_last%0d", c), 64'(bus.ir_last), 64'd0);
    end
    bus.ir_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_w1", 64'(bus.ir_word), 64'hF2A00049);
    bus.ir_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_w1_hold", 64'(bus.ir_word), 64'hF2A00049);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.ir_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    bus.ir_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.ir_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("no_replay", 64'(bus.ir_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
